// File: rtl/arc4_seq_pkg.sv
// Shared types and constants for the ARC4 pass sequencer.
// Holds the sequencer state enum, the S-port owner enum and an owner decode.
package arc4_pkg;

    localparam int S_DEPTH = 256;
    localparam int ADDR_W  = 8;
    localparam int KEY_W   = 24;

    typedef enum logic [3:0] {
        IDLE,
        INIT_GO,
        INIT_ARM,
        INIT_RUN,
        KSA_GO,
        KSA_ARM,
        KSA_RUN,
        PRGA_GO,
        PRGA_ARM,
        PRGA_RUN
    } seq_state_e;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_INIT,
        OWN_KSA,
        OWN_PRGA
    } owner_e;

    // Every state of a phase, including its GO and ARM cycles,
    // gives the S port to that phase's block.
    function automatic owner_e owner_of(input seq_state_e s);
        case (s)
            INIT_GO, INIT_ARM, INIT_RUN: return OWN_INIT;
            KSA_GO, KSA_ARM, KSA_RUN:    return OWN_KSA;
            PRGA_GO, PRGA_ARM, PRGA_RUN: return OWN_PRGA;
            default:                     return OWN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/arc4_seq_s_port_mux.sv
// Shared S-memory write-port multiplexer.
// Ports: i_sel owner select; init/ksa/prga addr/wrdata/wren sets in;
// one shared s_addr/s_wrdata/s_wren set out (all zero when unowned).
module s_port_mux
    import arc4_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic [1:0]    i_sel,
    input  logic [AW-1:0] i_init_addr,
    input  logic [7:0]    i_init_wrdata,
    input  logic          i_init_wren,
    input  logic [AW-1:0] i_ksa_addr,
    input  logic [7:0]    i_ksa_wrdata,
    input  logic          i_ksa_wren,
    input  logic [AW-1:0] i_prga_addr,
    input  logic [7:0]    i_prga_wrdata,
    input  logic          i_prga_wren,
    output logic [AW-1:0] o_addr,
    output logic [7:0]    o_wrdata,
    output logic          o_wren
);

    owner_e w_sel;

    assign w_sel = owner_e'(i_sel);

    always_comb begin
        o_addr   = '0;
        o_wrdata = '0;
        o_wren   = 1'b0;
        case (w_sel)
            OWN_INIT: begin
                o_addr   = i_init_addr;
                o_wrdata = i_init_wrdata;
                o_wren   = i_init_wren;
            end
            OWN_KSA: begin
                o_addr   = i_ksa_addr;
                o_wrdata = i_ksa_wrdata;
                o_wren   = i_ksa_wren;
            end
            OWN_PRGA: begin
                o_addr   = i_prga_addr;
                o_wrdata = i_prga_wrdata;
                o_wren   = i_prga_wren;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/arc4_seq.sv
// ARC4 pass sequencer: runs init, ksa, prga in order and owns the S port.
// Ports: en/rdy upstream handshake + key; X_en/X_rdy per phase block;
// X_addr/X_wrdata/X_wren per phase in; shared s_* out; latched ksa/prga key.
// Optional macro ARC4_SEQ_CYCLE_CNT_EN adds a saturating 32-bit busy
// cycle counter on output port cycles.
module arc4_seq #(
    parameter int KEY_W  = 24,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic              rdy,
    input  logic [KEY_W-1:0]  key,
    output logic              init_en,
    input  logic              init_rdy,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [7:0]        init_wrdata,
    input  logic              init_wren,
    output logic              ksa_en,
    input  logic              ksa_rdy,
    output logic [KEY_W-1:0]  ksa_key,
    input  logic [ADDR_W-1:0] ksa_addr,
    input  logic [7:0]        ksa_wrdata,
    input  logic              ksa_wren,
    output logic              prga_en,
    input  logic              prga_rdy,
    output logic [KEY_W-1:0]  prga_key,
    input  logic [ADDR_W-1:0] prga_addr,
    input  logic [7:0]        prga_wrdata,
    input  logic              prga_wren,
`ifdef ARC4_SEQ_CYCLE_CNT_EN
    output logic [31:0]       cycles,
`endif
    output logic [ADDR_W-1:0] s_addr,
    output logic [7:0]        s_wrdata,
    output logic              s_wren
);

    import arc4_pkg::*;

    seq_state_e       r_state;
    seq_state_e       w_next;
    logic [KEY_W-1:0] r_key;
    owner_e           w_owner;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key <= '0;
        end else if (r_state == IDLE && en) begin
            r_key <= key;
        end
    end

    // X_ARM ignores X_rdy for one cycle so a block whose rdy drops a
    // cycle after its en is not mistaken for already finished.
    always_comb begin
        w_next  = r_state;
        rdy     = 1'b0;
        init_en = 1'b0;
        ksa_en  = 1'b0;
        prga_en = 1'b0;
        case (r_state)
            IDLE: begin
                rdy = 1'b1;
                if (en) w_next = INIT_GO;
            end
            INIT_GO: begin
                if (init_rdy) begin
                    init_en = 1'b1;
                    w_next  = INIT_ARM;
                end
            end
            INIT_ARM: w_next = INIT_RUN;
            INIT_RUN: begin
                if (init_rdy) w_next = KSA_GO;
            end
            KSA_GO: begin
                if (ksa_rdy) begin
                    ksa_en = 1'b1;
                    w_next = KSA_ARM;
                end
            end
            KSA_ARM: w_next = KSA_RUN;
            KSA_RUN: begin
                if (ksa_rdy) w_next = PRGA_GO;
            end
            PRGA_GO: begin
                if (prga_rdy) begin
                    prga_en = 1'b1;
                    w_next  = PRGA_ARM;
                end
            end
            PRGA_ARM: w_next = PRGA_RUN;
            PRGA_RUN: begin
                if (prga_rdy) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign ksa_key  = r_key;
    assign prga_key = r_key;
    assign w_owner  = owner_of(r_state);

    s_port_mux #(
        .AW(ADDR_W)
    ) u_mux (
        .i_sel         (w_owner),
        .i_init_addr   (init_addr),
        .i_init_wrdata (init_wrdata),
        .i_init_wren   (init_wren),
        .i_ksa_addr    (ksa_addr),
        .i_ksa_wrdata  (ksa_wrdata),
        .i_ksa_wren    (ksa_wren),
        .i_prga_addr   (prga_addr),
        .i_prga_wrdata (prga_wrdata),
        .i_prga_wren   (prga_wren),
        .o_addr        (s_addr),
        .o_wrdata      (s_wrdata),
        .o_wren        (s_wren)
    );

`ifdef ARC4_SEQ_CYCLE_CNT_EN
    logic [31:0] r_cycles;

    // Busy cycles of the most recent pass; held while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycles <= '0;
        end else if (r_state == IDLE) begin
            if (en) r_cycles <= '0;
        end else if (r_cycles != 32'hFFFF_FFFF) begin
            r_cycles <= r_cycles + 32'd1;
        end
    end

    assign cycles = r_cycles;
`endif

endmodule
